wb_arbiter: RTL and testbench

- N-master to 1-slave Wishbone B4 classic arbiter for the uncore interconnect.
- Picks one requesting master with a priority encoder instance (WIDTH=PORTS).
- Holds the grant for the whole bus cycle, while m_cyc stays high.
- Muxes the granted master onto the shared slave port and routes ack/err back to that master only.

---
 rtl/wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_wb_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// N-master to 1-slave Wishbone B4 classic arbiter; grant is held for the whole bus cycle.
// Define WB_ARB_ROUND_ROBIN_EN to rotate priority between grants instead of fixed priority.

module wb_arb_pri_enc #(
    parameter int WIDTH    = 2,
    parameter int LSB_HIGH = 1
) (
    input  logic [WIDTH-1:0]         req,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     valid
);
    localparam int IW = $clog2(WIDTH);

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        idx   = '0;
        valid = |req;
        if (LSB_HIGH != 0) begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (req[i]) idx = IW'(i);
        end else begin
            for (int i = 0; i < WIDTH; i++)
                if (req[i]) idx = IW'(i);
        end
    end
endmodule

module wb_arbiter #(
    parameter int PORTS             = 2,
    parameter int ADDR_WIDTH        = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int SEL_WIDTH         = DATA_WIDTH / 8,
    parameter int LSB_HIGH_PRIORITY = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [PORTS-1:0]                m_cyc_i,
    input  logic [PORTS-1:0]                m_stb_i,
    input  logic [PORTS-1:0]                m_we_i,
    input  logic [PORTS*ADDR_WIDTH-1:0]     m_adr_i,
    input  logic [PORTS*DATA_WIDTH-1:0]     m_dat_i,
    input  logic [PORTS*SEL_WIDTH-1:0]      m_sel_i,
    output logic [DATA_WIDTH-1:0]           m_dat_o,
    output logic [PORTS-1:0]                m_ack_o,
    output logic [PORTS-1:0]                m_err_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [ADDR_WIDTH-1:0]           s_adr_o,
    output logic [DATA_WIDTH-1:0]           s_dat_o,
    output logic [SEL_WIDTH-1:0]            s_sel_o,
    input  logic [DATA_WIDTH-1:0]           s_dat_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    output logic [PORTS-1:0]                grant_o
);
    localparam int IW = $clog2(PORTS);

    logic          gnt_valid, nxt_valid;
    logic [IW-1:0] gnt_idx, nxt_idx;
    logic [IW-1:0] win;
    logic          win_valid;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [PORTS-1:0] mask, nxt_mask;
    logic [IW-1:0]    msk_win, raw_win;
    logic             msk_valid;

    wb_arb_pri_enc #(.WIDTH(PORTS), .LSB_HIGH(LSB_HIGH_PRIORITY)) u_enc_masked (
        .req(m_cyc_i & mask), .idx(msk_win), .valid(msk_valid));
    wb_arb_pri_enc #(.WIDTH(PORTS), .LSB_HIGH(LSB_HIGH_PRIORITY)) u_enc_raw (
        .req(m_cyc_i), .idx(raw_win), .valid(win_valid));

    assign win = msk_valid ? msk_win : raw_win;
`else
    wb_arb_pri_enc #(.WIDTH(PORTS), .LSB_HIGH(LSB_HIGH_PRIORITY)) u_enc (
        .req(m_cyc_i), .idx(win), .valid(win_valid));
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            mask      <= '1;
`endif
        end else begin
            gnt_valid <= nxt_valid;
            gnt_idx   <= nxt_idx;
`ifdef WB_ARB_ROUND_ROBIN_EN
            mask      <= nxt_mask;
`endif
        end
    end

    // Release always drops to idle first, so owners are separated by a dead cycle.
    always_comb begin
        nxt_valid = gnt_valid;
        nxt_idx   = gnt_idx;
`ifdef WB_ARB_ROUND_ROBIN_EN
        nxt_mask  = mask;
`endif
        if (!gnt_valid) begin
            if (win_valid) begin
                nxt_valid = 1'b1;
                nxt_idx   = win;
`ifdef WB_ARB_ROUND_ROBIN_EN
                for (int j = 0; j < PORTS; j++)
                    nxt_mask[j] = (LSB_HIGH_PRIORITY != 0) ? (j > int'(win)) : (j < int'(win));
`endif
            end
        end else if (!m_cyc_i[gnt_idx]) begin
            nxt_valid = 1'b0;
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        m_ack_o = '0;
        m_err_o = '0;
        grant_o = '0;
        s_adr_o = m_adr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_o = m_dat_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        s_sel_o = m_sel_i[int'(gnt_idx)*SEL_WIDTH +: SEL_WIDTH];
        m_dat_o = s_dat_i;
        if (gnt_valid) begin
            s_cyc_o          = m_cyc_i[gnt_idx];
            s_stb_o          = m_stb_i[gnt_idx];
            s_we_o           = m_we_i[gnt_idx];
            grant_o[gnt_idx] = 1'b1;
            // Responses without an active strobe are stray and never forwarded.
            if (m_stb_i[gnt_idx]) begin
                m_ack_o[gnt_idx] = s_ack_i;
                m_err_o[gnt_idx] = s_err_i;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with four masters.
module tb_wb_arbiter;
    localparam int P  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [P-1:0]    m_cyc, m_stb, m_we;
    logic [P*AW-1:0] m_adr;
    logic [P*DW-1:0] m_dat;
    logic [P*SW-1:0] m_sel;
    logic [DW-1:0]   m_rdat;
    logic [P-1:0]    m_ack, m_err, grant;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_wdat, s_rdat;
    logic [SW-1:0]   s_sel;
    logic            s_ack, s_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.PORTS(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .LSB_HIGH_PRIORITY(1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_dat_o(m_rdat), .m_ack_o(m_ack), .m_err_o(m_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
        .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(grant)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    int exp_order[5];
    logic [P-1:0] g;

    initial begin
        rst_n = 1'b0;
        m_cyc = 4'b0011; m_stb = 4'b0011; m_we = '0;
        m_adr = '0; m_dat = '0; m_sel = '0;
        s_rdat = 32'hCAFE_F00D; s_ack = 1'b1; s_err = 1'b0;

        // Reset held three edges with requests and a stray ack present
        repeat (3) tick();
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_ack", m_ack, 0);
        chk("rst_grant", grant, 0);
        chk("rdat_bcast", m_rdat, 32'hCAFE_F00D);
        s_ack = 1'b0;
        rst_n = 1'b1;
        settle();
        chk("rst_rel_grant", grant, 0);

        // Contention: master 0 wins, one dead cycle, then master 1
        tick();
        chk("cont_g0", grant, 4'b0001);
        chk("cont_s_cyc", s_cyc, 1);
        s_ack = 1'b1;
        settle();
        chk("cont_ack0", m_ack, 4'b0001);
        tick();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        settle();
        chk("cont_cyc_drop", s_cyc, 0);
        tick();
        chk("cont_dead", grant, 0);
        tick();
        chk("cont_g1", grant, 4'b0010);
        m_cyc = '0; m_stb = '0;
        tick();
        chk("cont_idle", grant, 0);

        // Single master 1 write, slave acks after 2 cycles
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
        m_adr[1*AW +: AW] = 32'h100;
        m_dat[1*DW +: DW] = 32'hDEAD_BEEF;
        m_sel[1*SW +: SW] = 4'hF;
        tick();
        chk("wr_grant", grant, 4'b0010);
        chk("wr_adr", s_adr, 32'h100);
        chk("wr_dat", s_wdat, 32'hDEAD_BEEF);
        chk("wr_sel", s_sel, 4'hF);
        chk("wr_we", s_we, 1);
        chk("wr_noack", m_ack, 0);
        tick();
        tick();
        s_ack = 1'b1;
        settle();
        chk("wr_ack", m_ack, 4'b0010);
        tick();
        s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
        settle();
        chk("wr_ack_once", m_ack, 0);
        tick();
        chk("wr_rel", grant, 0);

        // No preemption: master 0 arrives while master 1 owns the bus
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        tick();
        chk("np_g1", grant, 4'b0010);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick();
        chk("np_hold", grant, 4'b0010);
        m_stb[1] = 1'b0; s_ack = 1'b1;
        settle();
        chk("np_stray_ack", m_ack, 0);
        m_stb[1] = 1'b1;
        settle();
        chk("np_ack1", m_ack, 4'b0010);
        tick();
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        tick();
        chk("np_dead", grant, 0);
        tick();
        chk("np_g0", grant, 4'b0001);
        m_cyc = '0; m_stb = '0;
        tick();

        // Error path on a master 2 read
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        tick();
        chk("err_grant", grant, 4'b0100);
        chk("err_we", s_we, 0);
        s_err = 1'b1;
        settle();
        chk("err_err", m_err, 4'b0100);
        chk("err_noack", m_ack, 0);
        tick();
        s_err = 1'b0; m_cyc = '0; m_stb = '0;
        settle();
        chk("err_once", m_err, 0);
        tick();
        chk("err_rel", grant, 0);

        // Mid-transfer reset drops the grant, then all four masters keep requesting
        m_cyc = 4'b1111; m_stb = 4'b1111;
        tick();
        chk("mr_g0", grant, 4'b0001);
        rst_n = 1'b0;
        tick();
        chk("mr_lost", s_cyc, 0);
        rst_n = 1'b1;
        tick();
`ifdef WB_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("order%0d", n), grant, 4'(1 << exp_order[n]));
            g = grant;
            s_ack = 1'b1;
            settle();
            chk($sformatf("order_ack%0d", n), m_ack, g);
            tick();
            s_ack = 1'b0;
            m_cyc = m_cyc & ~g; m_stb = m_cyc;
            tick();
            chk($sformatf("order_dead%0d", n), grant, 0);
            m_cyc = 4'b1111; m_stb = 4'b1111;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
